slice_bus_driver: RTL and testbench

Sequential stimulus/response master for the sliced 41-bit A/B/C bus used by the multi-instance slice netlists. It drives the A and B lanes that a slice consumes, waits a fixed settle time, and captures the matching C lane. One 12-bit transaction is executed per request and returned over a valid/ready response channel. It sits between test/control logic and a hierarchy of 12-bit slice instances where some slices have unconnected B or C ports.

---
 rtl/slice_bus_driver_if.sv | 37 +++
 rtl/slice_bus_driver.sv | 174 +++++++++++++++++
 tb/tb_slice_bus_driver.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/slice_bus_driver_if.sv
// slice_bus_driver_if
//   Request, response and sliced A/B/C bus signals of slice_bus_driver.
//   master : the driver itself (consumes requests and C, drives A/B and responses)
//   slave  : the control/test side plus the slice hierarchy
//   Request  : in_valid, in_ready, in_slice, in_a, in_b
//   Bus      : A, B (to slices), C (from slices)
//   Response : resp_valid, resp_ready, resp_slice, resp_c, resp_nocap, resp_err
interface slice_bus_driver_if #(
  parameter int SLICE_W = 12,
  parameter int BUS_W   = 41,
  parameter int SEL_W   = 2
);
  logic               in_valid;
  logic               in_ready;
  logic [SEL_W-1:0]   in_slice;
  logic [SLICE_W-1:0] in_a;
  logic [SLICE_W-1:0] in_b;
  logic [BUS_W-1:0]   A;
  logic [BUS_W-1:0]   B;
  logic [BUS_W-1:0]   C;
  logic               resp_valid;
  logic               resp_ready;
  logic [SEL_W-1:0]   resp_slice;
  logic [SLICE_W-1:0] resp_c;
  logic               resp_nocap;
  logic               resp_err;

  modport master (
    input  in_valid, in_slice, in_a, in_b, C, resp_ready,
    output in_ready, A, B, resp_valid, resp_slice, resp_c, resp_nocap, resp_err
  );

  modport slave (
    output in_valid, in_slice, in_a, in_b, C, resp_ready,
    input  in_ready, A, B, resp_valid, resp_slice, resp_c, resp_nocap, resp_err
  );
endinterface

// File: rtl/slice_bus_driver.sv
// slice_bus_driver
//   Sequential stimulus/response master for the sliced A/B/C bus. A request
//   drives the A (and, where connected, B) lane of one slice, waits SETTLE
//   cycles, captures that slice's C lane and returns it on a valid/ready
//   response channel. Illegal slice indices answer immediately with resp_err.
//   Ports:
//     clk    clock
//     rst_n  asynchronous active-low reset
//     bus    slice_bus_driver_if.master (request, A/B/C bus, response)
//   Build option:
//     SLICE_DRV_HOLD_EN  defined: A/B keep their values after the response
//                        handshake until the next accepted request.
//                        undefined: A/B clear at the response handshake.
module slice_bus_driver #(
  parameter int          SLICE_W    = 12,
  parameter int          NUM_SLICES = 3,
  parameter int          BUS_W      = 41,
  parameter int          SETTLE     = 2,
  parameter logic [2:0]  B_MASK     = 3'b011,
  parameter logic [2:0]  C_MASK     = 3'b101
) (
  input  logic              clk,
  input  logic              rst_n,
  slice_bus_driver_if.master bus
);

  localparam int SEL_W = 2;
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q;
  logic [BUS_W-1:0]   a_q;
  logic [BUS_W-1:0]   b_q;
  logic               resp_valid_q;
  logic [SEL_W-1:0]   resp_slice_q;
  logic [SLICE_W-1:0] resp_c_q;
  logic               resp_nocap_q;
  logic               resp_err_q;

  logic               legal_d;
  logic [BUS_W-1:0]   a_d;
  logic [BUS_W-1:0]   b_d;
  logic [SLICE_W-1:0] c_lane_d;
  logic               c_conn_d;
  logic               unused_c;

  // Place a lane value into the bus position of slice sel; slices whose mask
  // bit is clear (unconnected port) stay 0.
  function automatic logic [BUS_W-1:0] lane_place(
    input logic [SEL_W-1:0]      sel,
    input logic [SLICE_W-1:0]    val,
    input logic [NUM_SLICES-1:0] mask
  );
    logic [BUS_W-1:0] lane;
    lane = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (int'(sel) == s && mask[s]) lane[s*SLICE_W +: SLICE_W] = val;
    end
    return lane;
  endfunction

  // Extract the C lane of slice sel; unconnected C ports read as 0.
  function automatic logic [SLICE_W-1:0] lane_pick(
    input logic [SEL_W-1:0] sel,
    input logic [BUS_W-1:0] cbus
  );
    logic [SLICE_W-1:0] res;
    res = '0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (int'(sel) == s && C_MASK[s]) res = cbus[s*SLICE_W +: SLICE_W];
    end
    return res;
  endfunction

  function automatic logic c_connected(input logic [SEL_W-1:0] sel);
    logic conn;
    conn = 1'b0;
    for (int s = 0; s < NUM_SLICES; s++) begin
      if (int'(sel) == s) conn = C_MASK[s];
    end
    return conn;
  endfunction

  assign legal_d  = int'(bus.in_slice) < NUM_SLICES;
  assign a_d      = lane_place(bus.in_slice, bus.in_a, {NUM_SLICES{1'b1}});
  assign b_d      = lane_place(bus.in_slice, bus.in_b, B_MASK[NUM_SLICES-1:0]);
  assign c_lane_d = lane_pick(resp_slice_q, bus.C);
  assign c_conn_d = c_connected(resp_slice_q);
  // C bits outside the selected slice (and above the used slices) are ignored.
  assign unused_c = ^bus.C;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      resp_valid_q <= 1'b0;
      resp_slice_q <= '0;
      resp_c_q     <= '0;
      resp_nocap_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            in_ready_q   <= 1'b0;
            resp_slice_q <= bus.in_slice;
            if (legal_d) begin
              // Whole-bus load also clears any lanes still held from the
              // previous transaction.
              a_q     <= a_d;
              b_q     <= b_d;
              cnt_q   <= CNT_W'(SETTLE - 1);
              state_q <= DRIVE;
            end else begin
              a_q          <= '0;
              b_q          <= '0;
              resp_err_q   <= 1'b1;
              resp_c_q     <= '0;
              resp_nocap_q <= 1'b0;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end
          end
        end
        DRIVE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            resp_c_q     <= c_lane_d;
            resp_nocap_q <= ~c_conn_d;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          // resp_valid is always high here, so resp_ready alone completes it.
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            state_q      <= IDLE;
`ifdef SLICE_DRV_HOLD_EN
            a_q <= a_q;
            b_q <= b_q;
`else
            a_q <= '0;
            b_q <= '0;
`endif
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_slice = resp_slice_q;
  assign bus.resp_c     = resp_c_q;
  assign bus.resp_nocap = resp_nocap_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_slice_bus_driver.sv
module tb_slice_bus_driver;
  localparam int         SW     = 12;
  localparam int         BW     = 41;
  localparam int         SETTLE = 2;
  localparam logic [2:0] BM     = 3'b011;
  localparam logic [2:0] CM     = 3'b101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slice_bus_driver_if #(.SLICE_W(SW), .BUS_W(BW), .SEL_W(2)) bus_if ();

  slice_bus_driver #(
    .SLICE_W(SW), .NUM_SLICES(3), .BUS_W(BW), .SETTLE(SETTLE),
    .B_MASK(BM), .C_MASK(CM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_if.master)
  );

  typedef struct {
    logic [1:0]    slice;
    logic [SW-1:0] c;
    logic          nocap;
    logic          err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every response at its handshake.
  always @(negedge clk) begin
    if (rst_n && bus_if.resp_valid && bus_if.resp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_resp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_slice", 64'(bus_if.resp_slice), 64'(e.slice));
        chk("resp_c", 64'(bus_if.resp_c), 64'(e.c));
        chk("resp_nocap", 64'(bus_if.resp_nocap), 64'(e.nocap));
        chk("resp_err", 64'(bus_if.resp_err), 64'(e.err));
      end
    end
  end

  task automatic run_txn(input int s, input logic [SW-1:0] a, input logic [SW-1:0] b,
                         input logic [BW-1:0] cbus, input int hold, input bit hs);
    logic [BW-1:0] ea, eb;
    exp_t e;
    int lat;
    bit legal;
    legal = (s < 3);
    ea = '0;
    eb = '0;
    e.slice = 2'(s);
    e.c = '0;
    e.nocap = 1'b0;
    e.err = !legal;
    if (legal) begin
      ea[s*SW +: SW] = a;
      if (BM[s]) eb[s*SW +: SW] = b;
      if (CM[s]) e.c = cbus[s*SW +: SW];
      e.nocap = !CM[s];
    end
    @(posedge clk); #1;
    bus_if.in_valid = 1'b1;
    bus_if.in_slice = 2'(s);
    bus_if.in_a = a;
    bus_if.in_b = b;
    bus_if.C = cbus;
    bus_if.resp_ready = 1'b0;
    @(negedge clk);
    chk("in_ready_idle", 64'(bus_if.in_ready), 1);
    @(posedge clk); #1;
    bus_if.in_valid = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    chk("A_after_accept", 64'(bus_if.A), 64'(ea));
    chk("B_after_accept", 64'(bus_if.B), 64'(eb));
    chk("in_ready_busy", 64'(bus_if.in_ready), 0);
    lat = 0;
    while (!bus_if.resp_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("resp_latency", 64'(lat), legal ? 64'(SETTLE) : 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus_if.resp_valid), 1);
      chk("hold_A", 64'(bus_if.A), 64'(ea));
      chk("hold_resp_c", 64'(bus_if.resp_c), 64'(e.c));
    end
    if (hs) begin
      @(posedge clk); #1;
      bus_if.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus_if.resp_ready = 1'b0;
      @(negedge clk);
      chk("valid_after_hs", 64'(bus_if.resp_valid), 0);
      chk("in_ready_after_hs", 64'(bus_if.in_ready), 1);
      chk("err_after_hs", 64'(bus_if.resp_err), 0);
`ifdef SLICE_DRV_HOLD_EN
      chk("A_after_hs", 64'(bus_if.A), 64'(ea));
      chk("B_after_hs", 64'(bus_if.B), 64'(eb));
`else
      chk("A_after_hs", 64'(bus_if.A), 0);
      chk("B_after_hs", 64'(bus_if.B), 0);
`endif
    end
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_in_ready"}, 64'(bus_if.in_ready), 1);
    chk({pfx, "_A"}, 64'(bus_if.A), 0);
    chk({pfx, "_B"}, 64'(bus_if.B), 0);
    chk({pfx, "_resp_valid"}, 64'(bus_if.resp_valid), 0);
    chk({pfx, "_resp_slice"}, 64'(bus_if.resp_slice), 0);
    chk({pfx, "_resp_c"}, 64'(bus_if.resp_c), 0);
    chk({pfx, "_resp_nocap"}, 64'(bus_if.resp_nocap), 0);
    chk({pfx, "_resp_err"}, 64'(bus_if.resp_err), 0);
  endtask

  function automatic logic [BW-1:0] rnd_bus();
    logic [BW-1:0] v;
    v = {$urandom, $urandom};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [BW-1:0] cb;
    bus_if.in_valid = 1'b0;
    bus_if.in_slice = '0;
    bus_if.in_a = '0;
    bus_if.in_b = '0;
    bus_if.C = '0;
    bus_if.resp_ready = 1'b0;
    #12;
    chk_reset_state("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_state("idle");

    cb = rnd_bus(); cb[11:0] = 12'h123;
    run_txn(0, 12'hA5A, 12'h0F0, cb, 0, 1);
    cb = rnd_bus(); cb[23:12] = 12'h555;
    run_txn(1, 12'h3C3, 12'hFFF, cb, 0, 1);
    cb = rnd_bus(); cb[35:24] = 12'h9E7;
    run_txn(2, 12'h7E1, 12'hFFF, cb, 0, 1);
    run_txn(3, 12'hBAD, 12'hBAD, rnd_bus(), 0, 1);
    for (int i = 0; i < 6; i++) begin
      run_txn(int'($urandom_range(0, 3)), 12'($urandom), 12'($urandom), rnd_bus(), i % 3, 1);
    end

    // Stall the response, then reset in the middle of RESP.
    cb = rnd_bus();
    run_txn(0, 12'h5A5, 12'h00F, cb, 5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    cb = rnd_bus();
    run_txn(2, 12'h1F1, 12'h2E2, cb, 1, 1);

    repeat (3) @(negedge clk);
    chk("sb_leftover", 64'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
